// File: rtl/frame_window_downloader_pkg.sv
// Shared types for the frame window downloader: FSM states and FIFO marker words.
package frame_window_downloader_types;

  typedef enum logic [3:0] {
    IDLE,
    CHECK_CFG,
    CALC_ADDR,
    PUSH_FSTART,
    ROW_START,
    REQ,
    WAIT_ACK,
    FILL,
    DRAIN,
    PUSH_FEND,
    DONE
  } t_state;

  // Bit 16 set marks a control word; pixel words carry a 0 there.
  localparam logic [16:0] MARK_FRAME_START = 17'h1_0000;
  localparam logic [16:0] MARK_ROW_START   = 17'h1_0001;
  localparam logic [16:0] MARK_FRAME_END   = 17'h1_FFFF;

endpackage

// File: rtl/frame_window_downloader_burst_cache.sv
// One-burst register file: 32-bit synchronous write, combinational 16-bit pixel read.
module burst_cache #(
  parameter int WORDS = 8,
  localparam int AW = $clog2(WORDS),
  localparam int PW = $clog2(WORDS * 2)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [PW-1:0] pix_idx_i,
  output logic [15:0]   pix_o
);

  logic [31:0] mem_q [WORDS];
  logic [31:0] rd_word;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Even pixel index selects the low half-word (first pixel of the pair).
  assign rd_word = mem_q[pix_idx_i[PW-1:1]];
  assign pix_o   = pix_idx_i[0] ? rd_word[31:16] : rd_word[15:0];

endmodule

// File: rtl/frame_window_downloader.sv
// Reads a FRAME_WIDTH x FRAME_HEIGHT window out of a stored frame in SDRAM, one burst
// at a time, and streams it into the display FIFO framed by start/row/end markers.
module frame_window_downloader
  import frame_window_downloader_types::*;
#(
  parameter int MEMORY_BURST      = 32,
  parameter int FRAME_WIDTH       = 480,
  parameter int FRAME_HEIGHT      = 272,
  parameter int ORIG_FRAME_WIDTH  = 640,
  parameter int ORIG_FRAME_HEIGHT = 480,
  parameter int ADDR_WIDTH        = 21,
  parameter int PIXEL_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [10:0]           x_offset,
  input  logic [10:0]           y_offset,
  input  logic                  queue_full,
  input  logic                  read_ack,
  input  logic [31:0]           read_data,
  input  logic                  rd_data_valid,
  output logic [PIXEL_WIDTH:0]  queue_data_o,
  output logic                  wr_en,
  output logic                  read_rq,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  mem_rd_en,
  output logic                  busy,
  output logic                  download_done,
  output logic                  cfg_error
);

  localparam int BURST_WORDS  = MEMORY_BURST / 4;
  localparam int BURST_PIXELS = MEMORY_BURST / 2;
  localparam int WA           = $clog2(BURST_WORDS);
  localparam int PIX_IDX_W    = $clog2(BURST_PIXELS);
  localparam logic [10:0] FW  = 11'(FRAME_WIDTH);
  localparam logic [10:0] FH  = 11'(FRAME_HEIGHT);
  localparam logic [10:0] BP  = 11'(BURST_PIXELS);
  localparam logic [10:0] BW  = 11'(BURST_WORDS);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ORIG_FRAME_WIDTH);

  t_state                state_q;
  logic [ADDR_WIDTH-1:0] base_q, row_base_q, addr_q;
  logic [10:0]           x_off_q, y_off_q, row_q, col_q, word_cnt_q, pix_ptr_q;
  logic [10:0]           col_inc, pix_inc;
  logic [12:0]           x_end, y_end;
  logic                  win_bad, can_wr, cache_we;
  logic [15:0]           cache_pix;

  assign x_end    = 13'(x_off_q) + 13'(FRAME_WIDTH);
  assign y_end    = 13'(y_off_q) + 13'(FRAME_HEIGHT);
  assign win_bad  = (x_end > 13'(ORIG_FRAME_WIDTH)) || (y_end > 13'(ORIG_FRAME_HEIGHT));
  // A write is issued only if the FIFO had room and we did not write last cycle.
  assign can_wr   = !queue_full && !wr_en;
  assign cache_we = (state_q == FILL) && rd_data_valid && (word_cnt_q < BW);
  assign col_inc  = col_q + 11'd1;
  assign pix_inc  = pix_ptr_q + 11'd1;

  burst_cache #(.WORDS(BURST_WORDS)) u_cache (
    .clk       (clk),
    .we_i      (cache_we),
    .waddr_i   (word_cnt_q[WA-1:0]),
    .wdata_i   (read_data),
    .pix_idx_i (pix_ptr_q[PIX_IDX_W-1:0]),
    .pix_o     (cache_pix)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      base_q        <= '0;
      row_base_q    <= '0;
      addr_q        <= '0;
      x_off_q       <= '0;
      y_off_q       <= '0;
      row_q         <= '0;
      col_q         <= '0;
      word_cnt_q    <= '0;
      pix_ptr_q     <= '0;
      queue_data_o  <= '0;
      wr_en         <= 1'b0;
      read_rq       <= 1'b0;
      read_addr     <= '0;
      mem_rd_en     <= 1'b0;
      busy          <= 1'b0;
      download_done <= 1'b0;
      cfg_error     <= 1'b0;
    end else begin
      wr_en         <= 1'b0;
      mem_rd_en     <= 1'b0;
      download_done <= 1'b0;
      cfg_error     <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          base_q  <= base_addr;
          x_off_q <= x_offset;
          y_off_q <= y_offset;
          busy    <= 1'b1;
          state_q <= CHECK_CFG;
        end
        CHECK_CFG: if (win_bad) begin
          cfg_error <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end else begin
          state_q <= CALC_ADDR;
        end
        CALC_ADDR: begin
          row_base_q <= base_q + ADDR_WIDTH'(y_off_q) * STRIDE + ADDR_WIDTH'(x_off_q);
          row_q      <= '0;
          state_q    <= PUSH_FSTART;
        end
        PUSH_FSTART: if (can_wr) begin
          wr_en        <= 1'b1;
          queue_data_o <= (PIXEL_WIDTH+1)'(MARK_FRAME_START);
          state_q      <= ROW_START;
        end
        ROW_START: if (row_q == FH) begin
          state_q <= PUSH_FEND;
        end else if (can_wr) begin
          wr_en        <= 1'b1;
          queue_data_o <= (PIXEL_WIDTH+1)'(MARK_ROW_START);
          col_q        <= '0;
          addr_q       <= row_base_q;
          state_q      <= REQ;
        end
        REQ: begin
          read_addr <= addr_q;
          read_rq   <= 1'b1;
          state_q   <= WAIT_ACK;
        end
        WAIT_ACK: if (read_ack) begin
          mem_rd_en  <= 1'b1;
          word_cnt_q <= '0;
          state_q    <= FILL;
        end
        FILL: if (word_cnt_q == BW) begin
          read_rq   <= 1'b0;
          pix_ptr_q <= '0;
          state_q   <= DRAIN;
        end else if (rd_data_valid) begin
          word_cnt_q <= word_cnt_q + 11'd1;
        end
        DRAIN: if (can_wr) begin
          wr_en        <= 1'b1;
          queue_data_o <= {1'b0, PIXEL_WIDTH'(cache_pix)};
          col_q        <= col_inc;
          pix_ptr_q    <= pix_inc;
          // Burst exhausted or row complete; the last burst of a row may be partial.
          if (pix_inc == BP || col_inc == FW) begin
            if (col_inc < FW) begin
              addr_q  <= addr_q + ADDR_WIDTH'(pix_inc);
              state_q <= REQ;
            end else begin
              row_base_q <= row_base_q + STRIDE;
              row_q      <= row_q + 11'd1;
              state_q    <= ROW_START;
            end
          end
        end
        PUSH_FEND: if (can_wr) begin
          wr_en        <= 1'b1;
          queue_data_o <= (PIXEL_WIDTH+1)'(MARK_FRAME_END);
          state_q      <= DONE;
        end
        DONE: begin
          download_done <= 1'b1;
          busy          <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_window_downloader.sv
// Directed bench: 20x2 window inside a 640x480 frame, arbiter/SDRAM model and FIFO monitor.
module tb_frame_window_downloader;

  logic        clk = 1'b0;
  logic        reset, start, queue_full, read_ack, rd_data_valid;
  logic [20:0] base_addr;
  logic [10:0] x_offset, y_offset;
  logic [31:0] read_data;
  logic [16:0] queue_data_o;
  logic        wr_en, read_rq, mem_rd_en, busy, download_done, cfg_error;
  logic [20:0] read_addr;

  int total = 0;
  int bad   = 0;

  logic [16:0] wr_log[$];
  logic [20:0] burst_log[$];
  int   done_cnt = 0, cfg_cnt = 0, rq_cycles = 0, viol_cnt = 0;
  logic full_prev = 1'b0, wr_prev = 1'b0;
  int   extra_valids = 0;

  always #5 clk = ~clk;

  frame_window_downloader #(
    .MEMORY_BURST(32), .FRAME_WIDTH(20), .FRAME_HEIGHT(2),
    .ORIG_FRAME_WIDTH(640), .ORIG_FRAME_HEIGHT(480),
    .ADDR_WIDTH(21), .PIXEL_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .x_offset(x_offset), .y_offset(y_offset), .queue_full(queue_full),
    .read_ack(read_ack), .read_data(read_data), .rd_data_valid(rd_data_valid),
    .queue_data_o(queue_data_o), .wr_en(wr_en), .read_rq(read_rq),
    .read_addr(read_addr), .mem_rd_en(mem_rd_en), .busy(busy),
    .download_done(download_done), .cfg_error(cfg_error)
  );

  // Stored-frame content as a function of pixel address.
  function automatic logic [15:0] pix(input logic [20:0] p);
    return p[15:0] ^ {p[20:16], 11'h2A5};
  endfunction

  // FIFO / protocol monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_log.push_back(queue_data_o);
      if (full_prev || wr_prev) viol_cnt <= viol_cnt + 1;
    end
    wr_prev   <= wr_en;
    full_prev <= queue_full;
    if (download_done) done_cnt  <= done_cnt + 1;
    if (cfg_error)     cfg_cnt   <= cfg_cnt + 1;
    if (read_rq)       rq_cycles <= rq_cycles + 1;
  end

  // Arbiter + SDRAM model: grant, then 8 words once mem_rd_en is seen.
  initial begin : arbiter
    logic [20:0] ra;
    read_ack = 1'b0; rd_data_valid = 1'b0; read_data = '0;
    forever begin
      @(posedge clk); #1;
      if (read_rq === 1'b1) begin
        ra = read_addr;
        burst_log.push_back(ra);
        read_ack = 1'b1;
        @(posedge clk); #1;
        read_ack = 1'b0;
        for (int t = 0; t < 8 && mem_rd_en !== 1'b1; t++) begin @(posedge clk); #1; end
        for (int k = 0; k < 8; k++) begin
          read_data = {pix(ra + 21'(2*k+1)), pix(ra + 21'(2*k))};
          rd_data_valid = 1'b1;
          @(posedge clk); #1;
        end
        for (int k = 0; k < extra_valids; k++) begin
          read_data = 32'hDEAD_BEEF ^ 32'(k);
          rd_data_valid = 1'b1;
          @(posedge clk); #1;
        end
        rd_data_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input string tag, input logic [20:0] b, input logic [10:0] x,
                          input logic [10:0] y, input logic [20:0] ea0, input logic [20:0] ea1,
                          input logic [20:0] ea2, input logic [20:0] ea3,
                          input int stall_at, input int start_len);
    int          w0, b0, d0, v0, stall_left, fb;
    bit          done_seen, stalled;
    logic [20:0] p;
    logic [16:0] got;
    logic [20:0] gota;
    logic [16:0] exp_q[$];
    logic [20:0] ea[4];
    ea[0] = ea0; ea[1] = ea1; ea[2] = ea2; ea[3] = ea3;
    w0 = wr_log.size(); b0 = burst_log.size(); d0 = done_cnt; v0 = viol_cnt;
    stalled = 0; stall_left = 0; done_seen = 0;
    base_addr = b; x_offset = x; y_offset = y; start = 1'b1;
    tick();
    check({tag, " busy_after_start"}, 32'(busy), 1);
    for (int i = 1; i < start_len; i++) tick();
    start = 1'b0;
    for (int t = 0; t < 3000 && !done_seen; t++) begin
      tick();
      if (stall_at > 0 && !stalled && (wr_log.size() - w0) >= stall_at) begin
        queue_full = 1'b1; stalled = 1; stall_left = 5;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) queue_full = 1'b0;
      end
      done_seen = (done_cnt != d0);
    end
    check({tag, " done_within_budget"}, 32'(done_seen), 1);
    tick(); tick();
    exp_q.push_back(17'h1_0000);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(17'h1_0001);
      for (int c = 0; c < 20; c++) begin
        p = b + 21'((int'(y) + r) * 640 + int'(x) + c);
        exp_q.push_back({1'b0, pix(p)});
      end
    end
    exp_q.push_back(17'h1_FFFF);
    check({tag, " write_count"}, 32'(wr_log.size() - w0), 44);
    for (int i = 0; i < exp_q.size(); i++) begin
      fb  = bad;
      got = (w0 + i < wr_log.size()) ? wr_log[w0 + i] : 'x;
      check($sformatf("%s word%0d", tag, i), 32'(got), 32'(exp_q[i]));
      if (bad != fb) break;
    end
    check({tag, " burst_count"}, 32'(burst_log.size() - b0), 4);
    for (int i = 0; i < 4; i++) begin
      gota = (b0 + i < burst_log.size()) ? burst_log[b0 + i] : 'x;
      check($sformatf("%s burst_addr%0d", tag, i), 32'(gota), 32'(ea[i]));
    end
    check({tag, " done_pulses"}, 32'(done_cnt - d0), 1);
    check({tag, " busy_idle"}, 32'(busy), 0);
    check({tag, " read_rq_idle"}, 32'(read_rq), 0);
    check({tag, " fifo_protocol"}, 32'(viol_cnt - v0), 0);
  endtask

  task automatic do_reject(input string tag, input logic [10:0] x, input logic [10:0] y);
    int w0, c0, r0;
    w0 = wr_log.size(); c0 = cfg_cnt; r0 = rq_cycles;
    base_addr = 21'h0; x_offset = x; y_offset = y; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check({tag, " cfg_error_pulses"}, 32'(cfg_cnt - c0), 1);
    check({tag, " writes"}, 32'(wr_log.size() - w0), 0);
    check({tag, " read_rq_cycles"}, 32'(rq_cycles - r0), 0);
    check({tag, " busy"}, 32'(busy), 0);
  endtask

  initial begin : main
    int w_rst;
    reset = 1'b1; start = 1'b0; queue_full = 1'b0;
    base_addr = '0; x_offset = '0; y_offset = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset wr_en", 32'(wr_en), 0);
    check("reset read_rq", 32'(read_rq), 0);
    check("reset busy", 32'(busy), 0);
    check("reset queue_data_o", 32'(queue_data_o), 0);
    reset = 1'b0;
    tick(); tick();

    // Window at (3,1): bursts base+643, base+659 (second one only 4 pixels), FIFO stall mid-drain.
    do_frame("win31", 21'h100, 11'd3, 11'd1, 21'h383, 21'h393, 21'h603, 21'h613, 6, 1);
    do_reject("xbad", 11'd621, 11'd0);
    do_reject("ybad", 11'd0, 11'd479);
    // Largest legal offsets; start held for several cycles must not retrigger.
    do_frame("edge", 21'h0, 11'd620, 11'd478, 21'h4AD6C, 21'h4AD7C, 21'h4AFEC, 21'h4AFFC, 0, 3);
    extra_valids = 12;
    do_frame("wrap", 21'h1FFFF8, 11'd0, 11'd0, 21'h1FFFF8, 21'h000008, 21'h000278, 21'h000288, 0, 1);
    extra_valids = 0;

    // Reset while a burst is being filled.
    base_addr = 21'h100; x_offset = '0; y_offset = '0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 50 && mem_rd_en !== 1'b1; t++) tick();
    check("rstfill mem_rd_en_seen", 32'(mem_rd_en), 1);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    check("rstfill wr_en", 32'(wr_en), 0);
    check("rstfill read_rq", 32'(read_rq), 0);
    check("rstfill mem_rd_en", 32'(mem_rd_en), 0);
    check("rstfill busy", 32'(busy), 0);
    check("rstfill download_done", 32'(download_done), 0);
    check("rstfill cfg_error", 32'(cfg_error), 0);
    check("rstfill queue_data_o", 32'(queue_data_o), 0);
    check("rstfill read_addr", 32'(read_addr), 0);
    tick();
    reset = 1'b0;
    w_rst = wr_log.size();
    repeat (12) tick();
    check("rstfill late_valid_writes", 32'(wr_log.size() - w_rst), 0);
    check("rstfill busy_after", 32'(busy), 0);
    check("rstfill read_rq_after", 32'(read_rq), 0);
    do_frame("after_rst", 21'h100, 11'd0, 11'd0, 21'h100, 21'h110, 21'h380, 21'h390, 20, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_window_downloader.md
Name: frame_window_downloader

Overview:
Parametrised successor to the frame downloader. It reads a FRAME_WIDTH x FRAME_HEIGHT window of 16-bit pixels from SDRAM, at a runtime-selectable x/y offset inside an ORIG_FRAME_WIDTH-wide stored frame. It pushes the pixels, framed with start, row and end markers, into the display FIFO. It sits between the memory arbiter read port and the LCD output queue.

Parameters:
MEMORY_BURST, 32, burst length in bytes; BURST_WORDS = MEMORY_BURST/4 (32-bit words), BURST_PIXELS = MEMORY_BURST/2.
FRAME_WIDTH, 480, output window width in pixels.
FRAME_HEIGHT, 272, output window height in rows.
ORIG_FRAME_WIDTH, 640, stored frame row stride in pixels.
ORIG_FRAME_HEIGHT, 480, stored frame height in rows.
ADDR_WIDTH, 21, memory address width (pixel-granular).
PIXEL_WIDTH, 16, pixel width; queue word is PIXEL_WIDTH+1 bits.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin one frame download; sampled only in IDLE
base_addr  in  ADDR_WIDTH  frame base; sampled with start
x_offset  in  11  window column offset; sampled with start
y_offset  in  11  window row offset; sampled with start
queue_full  in  1  FIFO full
read_ack  in  1  arbiter grant for the pending read_rq
read_data  in  32  burst data word, 2 pixels, low half first
rd_data_valid  in  1  read_data valid
queue_data_o  out  PIXEL_WIDTH+1  FIFO word, meaningful only when wr_en=1
wr_en  out  1  FIFO write strobe
read_rq  out  1  memory read request, held until the burst completes
read_addr  out  ADDR_WIDTH  burst start address
mem_rd_en  out  1  one-cycle read command pulse after read_ack
busy  out  1  high from start acceptance to download_done
download_done  out  1  one-cycle pulse after the end marker is written
cfg_error  out  1  one-cycle pulse when a window is rejected

Behaviour:
- Reset (async, any state): state=IDLE. wr_en, read_rq, mem_rd_en, busy, download_done and cfg_error are 0. queue_data_o and read_addr are 0. Counters and the cache pointer are cleared. An in-flight burst is abandoned; late rd_data_valid is ignored.
- Markers: 1_0000h = frame start, 1_0001h = row start, 1_FFFFh = frame end. A pixel word is {1'b0, pixel}.
- FIFO writes: a write occurs only when queue_full is sampled low in the same cycle. wr_en lasts exactly one cycle. There is at most one write every 2 cycles. A stall holds state and data.
- IDLE: busy=0. If start=1, latch the inputs, set busy=1 and go to CHECK_CFG. start in any other state is ignored.
- CHECK_CFG: reject if x_offset+FRAME_WIDTH > ORIG_FRAME_WIDTH or y_offset+FRAME_HEIGHT > ORIG_FRAME_HEIGHT. On reject, pulse cfg_error, drop busy and go to IDLE, writing nothing. On accept, go to CALC_ADDR.
- CALC_ADDR: row_base = base_addr + y_offset*ORIG_FRAME_WIDTH + x_offset, computed modulo 2^ADDR_WIDTH with 1 cycle latency. Then go to PUSH_FSTART and write the frame start marker.
- ROW_START: if row==FRAME_HEIGHT, go to PUSH_FEND. Otherwise write the row start marker, set col=0 and addr=row_base, then go to REQ.
- REQ: read_addr=addr and read_rq=1, then go to WAIT_ACK.
- WAIT_ACK: on read_ack, pulse mem_rd_en for 1 cycle, clear word_cnt and go to FILL. read_rq stays high.
- FILL: each rd_data_valid stores read_data into cache[word_cnt] and increments word_cnt. When word_cnt==BURST_WORDS, drop read_rq, clear pix_ptr and go to DRAIN. Valids beyond BURST_WORDS are ignored.
- DRAIN: write cache pixel pix_ptr (pixel 2k = word k[15:0], pixel 2k+1 = word k[31:16]), then increment col and pix_ptr. Stop when pix_ptr==BURST_PIXELS or col==FRAME_WIDTH; a partial last burst is truncated.
  - If col<FRAME_WIDTH: addr += pix_ptr, go to REQ.
  - Else: row_base += ORIG_FRAME_WIDTH, row++, go to ROW_START.
- PUSH_FEND: write the end marker, then go to DONE.
- DONE: pulse download_done, drop busy and go to IDLE. A start in the same cycle is not accepted.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. Counters are 11 bits.
- Per frame: exactly 1 + FRAME_HEIGHT*(1+FRAME_WIDTH) + 1 FIFO writes, and FRAME_HEIGHT*ceil(FRAME_WIDTH/BURST_PIXELS) bursts.

Decomposition:
- Package frame_window_downloader_types holds:
  - t_state enum: IDLE, CHECK_CFG, CALC_ADDR, PUSH_FSTART, ROW_START, REQ, WAIT_ACK, FILL, DRAIN, PUSH_FEND, DONE.
  - Marker constants MARK_FRAME_START, MARK_ROW_START, MARK_FRAME_END.
- One sub-module, burst_cache: a BURST_WORDS x 32 simple dual-port register file. It has a synchronous write port and a combinational 16-bit pixel read port (pixel index to half-word mux).

Test Plan:
- FRAME_WIDTH=8, FRAME_HEIGHT=2, ORIG=16x4, base=100h, offsets 0, queue_full=0 -> 20 writes: 1_0000h, 1_0001h, 8 pixels, 1_0001h, 8 pixels, 1_FFFFh; bursts at 100h and 110h; one download_done.
- FRAME_WIDTH=20, MEMORY_BURST=32, x_offset=3, y_offset=1, ORIG=640 -> read_addr sequence base+643 then base+659; the second burst delivers only 4 pixels.
- Toggle queue_full high for 5 cycles mid-DRAIN -> no wr_en while full, no pixel lost or duplicated, order preserved.
- x_offset=200 with FRAME_WIDTH=480, ORIG=640 -> cfg_error pulse, zero writes, zero read_rq, busy back to 0.
- Assert reset during FILL -> all outputs 0 within the reset cycle; extra rd_data_valid ignored; next start produces a complete frame.
- base_addr=1F_FFF8h -> addresses wrap to 00_0008h correctly; 12 extra rd_data_valid pulses beyond BURST_WORDS do not corrupt the cache.
